enigma_rotor_seq: RTL and testbench
===================================

// Module: enigma_rotor_seq
// PURPOSE
//  Sequencer for a chain of NUM_ROTORS rotor datapath instances (valid/done per rotor).
//  Accepts one ASCII char per transaction from the host and steps the rotor positions like an odometer.
//  Routes the char through the rotors (encode: 0..N-1, decode: N-1..0) and returns the result.
//  Sits between the host byte stream and the rotor bank; the rotors hold wiring and offset config.
// PARAMETERS
//  NUM_ROTORS  3     number of rotor instances sequenced (1..8)
//  TIMEOUT     1023  max cycles to wait for a rotor done before aborting the char
// PORTS
//  clk        in   1    single clock, rising edge
//  reset      in   1    asynchronous, active-high reset
//  in_valid   in   1    host char valid
//  in_ready   out  1    high only in IDLE; transfer when in_valid&&in_ready
//  in_char    in   8    ASCII input char
//  in_dec     in   1    1=decode, 0=encode; sampled with in_char
//  out_valid  out  1    result valid; held until out_ready
//  out_ready  in   1    host accepts result
//  out_char   out  8    result char; stable while out_valid
//  out_err    out  1    qualifies out_valid: rotor timeout; out_char=in_char
//  rot_en     out  N    1-cycle step pulse per rotor
//  rot_valid  out  N    1-cycle start pulse to rotor k
//  rot_din    out  8    char to the active rotor (shared bus)
//  rot_dec    out  1    direction to all rotors = latched in_dec
//  rot_dout   in   8*N  rotor k output at [8k+:8]
//  rot_done   in   N    rotor k result ready
//  pos        out  5*N  odometer position of rotor k (0..25) at [5k+:5], for debug
// BEHAVIOUR
//  Reset values: in_ready=0 during reset and 1 after reset in IDLE.
//   out_valid, out_err, rot_en, rot_valid, rot_dec and pos are all 0; rot_din and out_char are 8'h00.
//  FSM IDLE->STEP->ISSUE->WAIT->(ISSUE|OUT)->IDLE.
//  IDLE: on a transfer, latch char and dec. If char is not in 'A'..'Z', go straight to OUT:
//   out_char=char and no stepping.
//  STEP (1 cycle): rot_en[0]=1 and pos[0]++.
//   rot_en[k+1]=1 iff pos[k] wraps 25->0 in this same cycle (ripple carry).
//   Stepping direction is always increment; rot_dec tells the rotor which way to rotate.
//  ISSUE (1 cycle): k = 0 first when encoding, N-1 first when decoding.
//   Assert rot_valid[k]; rot_din = current char. Clear the wait counter.
//  WAIT: on rot_done[k], current char <= rot_dout[k].
//   If k is the last rotor, go to OUT; else advance k and go to ISSUE.
//   The wait counter reaching TIMEOUT -> out_err=1, out_char=original char, go to OUT.
//   rot_done of non-active rotors is ignored.
//  OUT: out_valid=1 until out_ready, then IDLE. There is a 1-cycle bubble before in_ready returns.
//  Latency: in transfer -> out_valid = 1 + sum over k of (2 + rotor k done latency) cycles.
//  pos and stepping persist across chars; only reset clears them. pos wraps mod 26.
//  Reset mid-operation: abandon the char immediately, all outputs return to reset values, pos=0.
//  No other config path: the rotors are configured through their own set ports.
// STRUCTURE
//  Shared package enigma_pkg: ALPHA_LEN=26, CHAR_A=8'h41, CHAR_Z=8'h5A, seq FSM state encoding.
//  Sub-module enigma_odometer: N-digit mod-26 counter.
//   Input: step. Outputs: pos and the per-digit carry (carry drives rot_en).
// TESTING
//  Reset, then encode 'A' with rotor models returning din+1 -> out_char='D' (N=3).
//   Check pos=1/0/0 and rot_en=3'b001 once.
//  26 encodes -> on the 26th char rot_en=3'b011 and pos=0/1/0. After 676 chars rot_en=3'b111.
//  Decode 'C' with rotor k returning a tag -> issue order 2,1,0 and rot_dec=1 on every rot_valid.
//  in_char=8'h20 (space) -> out_char=8'h20 within 2 cycles. No rot_en and no rot_valid.
//  Rotor 1 never asserts done -> out_err=1 and out_char=in_char after TIMEOUT cycles.
//   Then the next char processes normally.
//  Hold out_ready=0 for 10 cycles -> out_valid and out_char stay stable and in_ready=0.
//   Assert reset in WAIT -> outputs and pos go to 0 the same cycle.

Source files
------------

// File: rtl/enigma_rotor_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : enigma_pkg
//  Purpose  : Shared constants and sequencer state encoding for the rotor chain.
//  Revision : 1.0
// ============================================================================
package enigma_pkg;

    localparam int         ALPHA_LEN = 26;
    localparam logic [7:0] CHAR_A    = 8'h41;
    localparam logic [7:0] CHAR_Z    = 8'h5A;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_STEP  = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_OUT   = 3'd4
    } seq_state_t;

    function automatic logic is_upper(input logic [7:0] c);
        return (c >= CHAR_A) && (c <= CHAR_Z);
    endfunction

endpackage
`default_nettype wire

// File: rtl/enigma_rotor_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : enigma_rotor_seq_if
//  Purpose  : Host byte stream plus rotor-bank bus seen by the sequencer.
//  Revision : 1.0
// ============================================================================
interface enigma_rotor_seq_if #(
    parameter int NUM_ROTORS = 3
);
    import enigma_pkg::*;

    logic                      in_valid;
    logic                      in_ready;
    logic [7:0]                in_char;
    logic                      in_dec;
    logic                      out_valid;
    logic                      out_ready;
    logic [7:0]                out_char;
    logic                      out_err;
    logic [NUM_ROTORS-1:0]     rot_en;
    logic [NUM_ROTORS-1:0]     rot_valid;
    logic [7:0]                rot_din;
    logic                      rot_dec;
    logic [8*NUM_ROTORS-1:0]   rot_dout;
    logic [NUM_ROTORS-1:0]     rot_done;
    logic [5*NUM_ROTORS-1:0]   pos;

    // Host and rotor bank together form the environment around the sequencer
    modport master (
        output in_valid, in_char, in_dec, out_ready, rot_dout, rot_done,
        input  in_ready, out_valid, out_char, out_err,
               rot_en, rot_valid, rot_din, rot_dec, pos
    );

    modport slave (
        input  in_valid, in_char, in_dec, out_ready, rot_dout, rot_done,
        output in_ready, out_valid, out_char, out_err,
               rot_en, rot_valid, rot_din, rot_dec, pos
    );

endinterface
`default_nettype wire

// File: rtl/enigma_rotor_seq_odometer.sv
`default_nettype none
// ============================================================================
//  Module   : enigma_odometer
//  Purpose  : N-digit mod-26 step counter; carry[k] is the step pulse for digit k.
//  Revision : 1.0
// ============================================================================
module enigma_odometer
    import enigma_pkg::*;
#(
    parameter int NUM_ROTORS = 3
) (
    input  wire logic                    clk,
    input  wire logic                    reset,
    input  wire logic                    step,
    output logic [5*NUM_ROTORS-1:0]      pos,
    output logic [NUM_ROTORS-1:0]        carry
);

    localparam logic [4:0] POS_MAX = 5'(ALPHA_LEN - 1);

    logic [NUM_ROTORS-1:0][4:0] pos_q, pos_d;
    logic [NUM_ROTORS-1:0]      wrap;

    for (genvar k = 0; k < NUM_ROTORS; k++) begin : g_digit
        assign wrap[k] = (pos_q[k] == POS_MAX);

        // A digit steps only when every lower digit wraps in the same cycle
        if (k == 0) begin : g_first
            assign carry[k] = step;
        end else begin : g_upper
            assign carry[k] = step & (&wrap[k-1:0]);
        end

        always_comb begin
            pos_d[k] = pos_q[k];
            if (carry[k]) begin
                pos_d[k] = wrap[k] ? 5'd0 : pos_q[k] + 5'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pos_q <= '0;
        end else begin
            pos_q <= pos_d;
        end
    end

    assign pos = pos_q;

endmodule
`default_nettype wire

// File: rtl/enigma_rotor_seq.sv
`default_nettype none
// ============================================================================
//  Module   : enigma_rotor_seq
//  Purpose  : Steps the rotor odometer and routes one char through the rotor chain.
//  Revision : 1.0
// ============================================================================
module enigma_rotor_seq
    import enigma_pkg::*;
#(
    parameter int NUM_ROTORS = 3,
    parameter int TIMEOUT    = 1023
) (
    input  wire logic          clk,
    input  wire logic          reset,
    enigma_rotor_seq_if.slave  bus
);

    localparam int                IDX_W    = (NUM_ROTORS > 1) ? $clog2(NUM_ROTORS) : 1;
    localparam int                CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_ROTORS - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(TIMEOUT);

    seq_state_t              state_q, state_d;
    logic [7:0]              char_q, char_d;
    logic [7:0]              orig_q, orig_d;
    logic [7:0]              out_char_q, out_char_d;
    logic                    dec_q, dec_d;
    logic                    out_err_q, out_err_d;
    logic                    in_ready_q, in_ready_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    logic                    step;
    logic                    last_rotor;
    logic [7:0]              dout_sel;
    logic [NUM_ROTORS-1:0]   rot_valid;
    logic [NUM_ROTORS-1:0]   rot_en;
    logic [5*NUM_ROTORS-1:0] pos;

    enigma_odometer #(
        .NUM_ROTORS (NUM_ROTORS)
    ) u_odometer (
        .clk   (clk),
        .reset (reset),
        .step  (step),
        .pos   (pos),
        .carry (rot_en)
    );

    assign dout_sel   = bus.rot_dout[8*idx_q +: 8];
    assign last_rotor = dec_q ? (idx_q == '0) : (idx_q == LAST_IDX);

    always_comb begin
        state_d    = state_q;
        char_d     = char_q;
        orig_d     = orig_q;
        out_char_d = out_char_q;
        dec_d      = dec_q;
        out_err_d  = out_err_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        in_ready_d = 1'b0;
        step       = 1'b0;
        rot_valid  = '0;

        case (state_q)
            S_IDLE: begin
                in_ready_d = 1'b1;
                if (bus.in_valid && in_ready_q) begin
                    in_ready_d = 1'b0;
                    char_d     = bus.in_char;
                    orig_d     = bus.in_char;
                    dec_d      = bus.in_dec;
                    out_err_d  = 1'b0;
                    idx_d      = bus.in_dec ? LAST_IDX : '0;
                    if (is_upper(bus.in_char)) begin
                        state_d = S_STEP;
                    end else begin
                        out_char_d = bus.in_char;
                        state_d    = S_OUT;
                    end
                end
            end
            S_STEP: begin
                step    = 1'b1;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                rot_valid[idx_q] = 1'b1;
                cnt_d            = '0;
                state_d          = S_WAIT;
            end
            S_WAIT: begin
                // A late done wins over a timeout landing in the same cycle
                if (bus.rot_done[idx_q]) begin
                    char_d = dout_sel;
                    if (last_rotor) begin
                        out_char_d = dout_sel;
                        state_d    = S_OUT;
                    end else begin
                        idx_d   = dec_q ? idx_q - IDX_W'(1) : idx_q + IDX_W'(1);
                        state_d = S_ISSUE;
                    end
                end else if (cnt_q == CNT_MAX) begin
                    out_err_d  = 1'b1;
                    out_char_d = orig_q;
                    state_d    = S_OUT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_OUT: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            char_q     <= 8'h00;
            orig_q     <= 8'h00;
            out_char_q <= 8'h00;
            dec_q      <= 1'b0;
            out_err_q  <= 1'b0;
            in_ready_q <= 1'b0;
            idx_q      <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            char_q     <= char_d;
            orig_q     <= orig_d;
            out_char_q <= out_char_d;
            dec_q      <= dec_d;
            out_err_q  <= out_err_d;
            in_ready_q <= in_ready_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = (state_q == S_OUT);
    assign bus.out_char  = out_char_q;
    assign bus.out_err   = out_err_q && (state_q == S_OUT);
    assign bus.rot_en    = rot_en;
    assign bus.rot_valid = rot_valid;
    assign bus.rot_din   = char_q;
    assign bus.rot_dec   = dec_q;
    assign bus.pos       = pos;

endmodule
`default_nettype wire

// File: tb/tb_enigma_rotor_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_enigma_rotor_seq
//  Purpose  : Directed self-checking bench with a simple rotor-bank model.
//  Revision : 1.0
// ============================================================================
module tb_enigma_rotor_seq;
    import enigma_pkg::*;

    localparam int NR      = 3;
    localparam int TIMEOUT = 1023;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    enigma_rotor_seq_if #(.NUM_ROTORS(NR)) bus ();

    enigma_rotor_seq #(
        .NUM_ROTORS (NR),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int fails  = 0;

    // Rotor model: mode 0 returns din+1, mode 1 returns tag '0'+k
    int         mode = 0;
    bit [NR-1:0] never = '0;
    bit [NR-1:0] pend  = '0;
    logic [7:0] din_lat [NR];

    int         en_cnt;
    logic [NR-1:0] en_log;
    int         issue_q[$];
    logic [7:0] din_q[$];
    bit         dec_all;

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_char   = 8'h00;
        bus.in_dec    = 1'b0;
        bus.out_ready = 1'b0;
        bus.rot_done  = '0;
        bus.rot_dout  = '0;
    end

    always @(negedge clk) begin
        if (bus.rot_en != '0) begin
            en_cnt++;
            en_log = bus.rot_en;
        end
        for (int k = 0; k < NR; k++) begin
            if (reset) begin
                pend[k]         = 1'b0;
                bus.rot_done[k] = 1'b0;
            end else if (bus.rot_valid[k]) begin
                pend[k]    = 1'b1;
                din_lat[k] = bus.rot_din;
                issue_q.push_back(k);
                din_q.push_back(bus.rot_din);
                dec_all = dec_all & bus.rot_dec;
            end else if (pend[k] && !never[k]) begin
                pend[k]                 = 1'b0;
                bus.rot_done[k]         = 1'b1;
                bus.rot_dout[8*k +: 8]  = (mode == 0) ? din_lat[k] + 8'd1 : 8'h30 + 8'(k);
            end else begin
                bus.rot_done[k] = 1'b0;
            end
        end
    end

    task automatic clear_logs();
        en_cnt  = 0;
        en_log  = '0;
        issue_q.delete();
        din_q.delete();
        dec_all = 1'b1;
    endtask

    task automatic do_reset();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        reset         = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic start_char(input logic [7:0] c, input logic d, output int lat);
        int n;
        n   = 0;
        lat = 0;
        @(negedge clk);
        while (bus.in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (bus.in_ready !== 1'b1) begin
            checks++;
            fails++;
            $display("FAIL in_ready_wait: in_ready=%b required 1", bus.in_ready);
            return;
        end
        bus.in_valid = 1'b1;
        bus.in_char  = c;
        bus.in_dec   = d;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        do begin
            @(negedge clk);
            lat++;
        end while (bus.out_valid !== 1'b1 && lat < 3000);
        if (bus.out_valid !== 1'b1) begin
            checks++;
            fails++;
            $display("FAIL out_valid_wait: out_valid=%b required 1", bus.out_valid);
        end
    endtask

    task automatic finish_char(output logic [7:0] oc, output logic err);
        oc            = bus.out_char;
        err           = bus.out_err;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
    endtask

    task automatic send_char(input logic [7:0] c, input logic d,
                             output logic [7:0] oc, output logic err, output int lat);
        start_char(c, d, lat);
        finish_char(oc, err);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.in_ready, bus.out_valid, bus.out_err, bus.rot_en, bus.rot_valid,
             bus.rot_dec, bus.pos, bus.rot_din, bus.out_char} !== 41'd0) begin
            fails++;
            $display("FAIL reset_outputs: rdy=%b ov=%b err=%b en=%b rv=%b dec=%b pos=%h din=%h oc=%h required all 0",
                     bus.in_ready, bus.out_valid, bus.out_err, bus.rot_en, bus.rot_valid,
                     bus.rot_dec, bus.pos, bus.rot_din, bus.out_char);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_in_ready: in_ready=%b required 1", bus.in_ready);
        end
    endtask

    task automatic test_encode_a();
        logic [7:0] oc;
        logic       err;
        int         lat;
        mode = 0;
        clear_logs();
        send_char(8'h41, 1'b0, oc, err, lat);
        checks++;
        if (oc !== 8'h44 || err !== 1'b0) begin
            fails++;
            $display("FAIL encode_a_out: char=%h err=%b required 44 0", oc, err);
        end
        checks++;
        if (bus.pos !== 15'd1) begin
            fails++;
            $display("FAIL encode_a_pos: pos=%h required 0001", bus.pos);
        end
        checks++;
        if (en_cnt !== 1 || en_log !== 3'b001) begin
            fails++;
            $display("FAIL encode_a_rot_en: pulses=%0d en=%b required 1 001", en_cnt, en_log);
        end
        checks++;
        if (issue_q.size() != 3) begin
            fails++;
            $display("FAIL encode_a_issue: issues=%0d required 3", issue_q.size());
        end else if (issue_q[0] != 0 || issue_q[1] != 1 || issue_q[2] != 2 ||
                     din_q[0] !== 8'h41 || din_q[1] !== 8'h42 || din_q[2] !== 8'h43) begin
            fails++;
            $display("FAIL encode_a_issue: order=%0d%0d%0d din=%h %h %h required 012 41 42 43",
                     issue_q[0], issue_q[1], issue_q[2], din_q[0], din_q[1], din_q[2]);
        end
    endtask

    task automatic test_decode_c();
        logic [7:0] oc;
        logic       err;
        int         lat;
        mode = 1;
        clear_logs();
        send_char(8'h43, 1'b1, oc, err, lat);
        checks++;
        if (oc !== 8'h30 || err !== 1'b0) begin
            fails++;
            $display("FAIL decode_c_out: char=%h err=%b required 30 0", oc, err);
        end
        checks++;
        if (issue_q.size() != 3) begin
            fails++;
            $display("FAIL decode_c_issue: issues=%0d required 3", issue_q.size());
        end else if (issue_q[0] != 2 || issue_q[1] != 1 || issue_q[2] != 0 ||
                     din_q[0] !== 8'h43 || din_q[1] !== 8'h32 || din_q[2] !== 8'h31) begin
            fails++;
            $display("FAIL decode_c_issue: order=%0d%0d%0d din=%h %h %h required 210 43 32 31",
                     issue_q[0], issue_q[1], issue_q[2], din_q[0], din_q[1], din_q[2]);
        end
        checks++;
        if (dec_all !== 1'b1) begin
            fails++;
            $display("FAIL decode_c_rot_dec: rot_dec_all=%b required 1", dec_all);
        end
        checks++;
        if (bus.pos !== 15'd2 || en_log !== 3'b001) begin
            fails++;
            $display("FAIL decode_c_pos: pos=%h en=%b required 0002 001", bus.pos, en_log);
        end
        mode = 0;
    endtask

    task automatic test_nonalpha();
        logic [7:0] oc;
        logic       err;
        int         lat;
        clear_logs();
        send_char(8'h20, 1'b0, oc, err, lat);
        checks++;
        if (oc !== 8'h20 || err !== 1'b0 || lat > 2) begin
            fails++;
            $display("FAIL nonalpha_out: char=%h err=%b latency=%0d required 20 0 <=2", oc, err, lat);
        end
        checks++;
        if (en_cnt != 0 || issue_q.size() != 0) begin
            fails++;
            $display("FAIL nonalpha_no_rotor: rot_en pulses=%0d issues=%0d required 0 0",
                     en_cnt, issue_q.size());
        end
    endtask

    task automatic test_timeout();
        logic [7:0] oc;
        logic       err;
        int         lat;
        never[1] = 1'b1;
        send_char(8'h41, 1'b0, oc, err, lat);
        checks++;
        if (oc !== 8'h41 || err !== 1'b1) begin
            fails++;
            $display("FAIL timeout_out: char=%h err=%b required 41 1", oc, err);
        end
        checks++;
        if (lat <= TIMEOUT || lat > TIMEOUT + 16) begin
            fails++;
            $display("FAIL timeout_latency: latency=%0d required %0d..%0d", lat, TIMEOUT + 1, TIMEOUT + 16);
        end
        never[1] = 1'b0;
        send_char(8'h42, 1'b0, oc, err, lat);
        checks++;
        if (oc !== 8'h45 || err !== 1'b0) begin
            fails++;
            $display("FAIL timeout_recover: char=%h err=%b required 45 0", oc, err);
        end
    endtask

    task automatic test_back_to_back_hold();
        logic [7:0] oc;
        logic       err;
        int         lat;
        start_char(8'h41, 1'b0, lat);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_char !== 8'h44 || bus.in_ready !== 1'b0) begin
                fails++;
                $display("FAIL hold_stable[%0d]: ov=%b char=%h rdy=%b required 1 44 0",
                         i, bus.out_valid, bus.out_char, bus.in_ready);
            end
        end
        finish_char(oc, err);
        checks++;
        if (oc !== 8'h44 || err !== 1'b0) begin
            fails++;
            $display("FAIL hold_result: char=%h err=%b required 44 0", oc, err);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] oc;
        logic       err;
        int         lat;
        do_reset();
        never[2] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_char  = 8'h41;
        bus.in_dec   = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (bus.pos !== 15'd1 || bus.rot_dec !== 1'b1 || bus.rot_din !== 8'h41) begin
            fails++;
            $display("FAIL midreset_pre: pos=%h dec=%b din=%h required 0001 1 41",
                     bus.pos, bus.rot_dec, bus.rot_din);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({bus.in_ready, bus.out_valid, bus.out_err, bus.rot_en, bus.rot_valid,
             bus.rot_dec, bus.pos, bus.rot_din, bus.out_char} !== 41'd0) begin
            fails++;
            $display("FAIL midreset_outputs: rdy=%b ov=%b err=%b en=%b rv=%b dec=%b pos=%h din=%h oc=%h required all 0",
                     bus.in_ready, bus.out_valid, bus.out_err, bus.rot_en, bus.rot_valid,
                     bus.rot_dec, bus.pos, bus.rot_din, bus.out_char);
        end
        never[2] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        send_char(8'h41, 1'b0, oc, err, lat);
        checks++;
        if (oc !== 8'h44 || err !== 1'b0 || bus.pos !== 15'd1) begin
            fails++;
            $display("FAIL midreset_recover: char=%h err=%b pos=%h required 44 0 0001", oc, err, bus.pos);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] oc;
        logic       err;
        int         lat;
        do_reset();
        for (int i = 1; i <= 676; i++) begin
            clear_logs();
            send_char(8'h41, 1'b0, oc, err, lat);
            if (i == 25) begin
                checks++;
                if (en_log !== 3'b001 || bus.pos !== {5'd0, 5'd0, 5'd25}) begin
                    fails++;
                    $display("FAIL wrap_25: en=%b pos=%h required 001 0019", en_log, bus.pos);
                end
            end
            if (i == 26) begin
                checks++;
                if (en_cnt != 1 || en_log !== 3'b011 || bus.pos !== {5'd0, 5'd1, 5'd0}) begin
                    fails++;
                    $display("FAIL wrap_26: pulses=%0d en=%b pos=%h required 1 011 0020",
                             en_cnt, en_log, bus.pos);
                end
            end
            if (i == 676) begin
                checks++;
                if (en_cnt != 1 || en_log !== 3'b111 || bus.pos !== {5'd1, 5'd0, 5'd0}) begin
                    fails++;
                    $display("FAIL wrap_676: pulses=%0d en=%b pos=%h required 1 111 0400",
                             en_cnt, en_log, bus.pos);
                end
            end
        end
    endtask

    initial begin
        clear_logs();
        test_reset();
        test_encode_a();
        test_decode_c();
        test_nonalpha();
        test_timeout();
        test_back_to_back_hold();
        test_reset_mid();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire
